// File: rtl/scfifo_s_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : scfifo_s_rd_stream
// Description : Read-side companion for a single-clock normal-mode scfifo.
//               Issues fifo_rdreq against a credit budget, captures fifo_q
//               after the fixed read latency into a small circular prefetch
//               buffer and presents it as a valid/ready stream at one word
//               per cycle. out_ready never reaches fifo_rdreq combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module scfifo_s_rd_stream #(
    parameter int WIDTH        = 20,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 4
) (
    input  logic                             clock,
    input  logic                             sclr,
    input  logic                             fifo_empty,
    input  logic [WIDTH-1:0]                 fifo_q,
    output logic                             fifo_rdreq,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   out_count
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    // Reject parameter values the credit/tag scheme is not built for.
    generate
        if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
            $error("scfifo_s_rd_stream: READ_LATENCY must be in 1..3");
        end
        if ((BUF_DEPTH < 2) || (BUF_DEPTH > 8)) begin : g_bad_depth
            $error("scfifo_s_rd_stream: BUF_DEPTH must be in 2..8");
        end
    endgenerate

    // Credits count words in flight plus words buffered; bounded by BUF_DEPTH.
    logic [CNT_W-1:0]        credits_q, credits_d;
    logic [CNT_W-1:0]        count_q,   count_d;
    logic [PTR_W-1:0]        wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q,  rd_ptr_d;
    logic [READ_LATENCY-1:0] tags_q,    tags_d;
    logic [WIDTH-1:0]        buf_q [BUF_DEPTH];

    logic issue;
    logic capture;
    logic pop;

    // Circular pointer advance with explicit wrap for non-power-of-2 depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Read issue depends only on fifo_empty, sclr and registered credits.
    assign issue      = !fifo_empty && (credits_q < DEPTH_CNT) && !sclr;
    assign fifo_rdreq = issue;

    // A tag leaving the latency pipe marks fifo_q as valid this cycle.
    assign capture    = tags_q[READ_LATENCY-1];

    assign out_valid  = (count_q != '0);
    assign out_data   = buf_q[rd_ptr_q];
    assign out_count  = count_q;
    assign pop        = out_valid && out_ready;

    // Tag pipe: one valid bit per outstanding read, shifted every cycle.
    generate
        if (READ_LATENCY == 1) begin : g_tag_single
            always_comb begin
                tags_d = issue;
            end
        end else begin : g_tag_shift
            always_comb begin
                tags_d = {tags_q[READ_LATENCY-2:0], issue};
            end
        end
    endgenerate

    // Next-state for pointers, occupancy and credits.
    always_comb begin
        wr_ptr_d  = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d   = count_q;
        case ({capture, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        credits_d = credits_q;
        case ({issue, pop})
            2'b10:   credits_d = credits_q + 1'b1;
            2'b01:   credits_d = credits_q - 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Control state; sclr also drops tags so late fifo_q words are ignored.
    always_ff @(posedge clock) begin
        if (sclr) begin
            credits_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tags_q    <= '0;
        end else begin
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tags_q    <= tags_d;
        end
    end

    // Buffer storage is not cleared; only the tag decides what is written.
    always_ff @(posedge clock) begin
        if (capture && !sclr) begin
            buf_q[wr_ptr_q] <= fifo_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scfifo_s_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_scfifo_s_rd_stream
// Description : Directed bench for scfifo_s_rd_stream across four parameter
//               sets, each with a sequence-numbered normal-mode FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scfifo_s_rd_stream;

    localparam int WIDTH  = 20;
    localparam int N_INST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sclr_v  [N_INST];
    logic ready_v [N_INST];
    int   wr_cnt  [N_INST];

    int n_vec = 0;
    int n_err = 0;

    // Word stored at FIFO position idx of instance k.
    function automatic logic [WIDTH-1:0] word_of(input int k, input int idx);
        return WIDTH'((k << 16) + idx + 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instances: 0 (RL1,BD4), 1 (RL3,BD5), 2 (RL2,BD4), 3 (RL1,BD3).
    for (genvar k = 0; k < N_INST; k++) begin : g_inst
        localparam int RL = (k == 1) ? 3 : (k == 2) ? 2 : 1;
        localparam int BD = (k == 1) ? 5 : (k == 3) ? 3 : 4;
        localparam int CW = $clog2(BD + 1);

        logic             empty;
        logic             rdreq;
        logic             valid;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] qd [RL];
        int               rd_cnt  = 0;
        int               exp_idx = 0;
        int               beats   = 0;

        assign empty = (rd_cnt == wr_cnt[k]);
        assign q     = qd[RL-1];

        scfifo_s_rd_stream #(
            .WIDTH        (WIDTH),
            .READ_LATENCY (RL),
            .BUF_DEPTH    (BD)
        ) u_dut (
            .clock      (clk),
            .sclr       (sclr_v[k]),
            .fifo_empty (empty),
            .fifo_q     (q),
            .fifo_rdreq (rdreq),
            .out_data   (data),
            .out_valid  (valid),
            .out_ready  (ready_v[k]),
            .out_count  (cnt)
        );

        // Normal-mode FIFO model: q carries the read word RL cycles later,
        // junk otherwise; sclr empties it without touching the q pipe.
        always @(posedge clk) begin
            if (sclr_v[k]) rd_cnt <= wr_cnt[k];
            else if (rdreq) rd_cnt <= rd_cnt + 1;
            qd[0] <= rdreq ? word_of(k, rd_cnt) : 20'hEEEEE;
            for (int i = 1; i < RL; i++) qd[i] <= qd[i-1];
        end

        // Per-cycle stream scoreboard and safety checks.
        always @(negedge clk) begin
            if (sclr_v[k]) begin
                exp_idx <= wr_cnt[k];
            end else begin
                check($sformatf("rdreq_while_empty[%0d]", k), 32'(rdreq & empty), 32'd0);
                check($sformatf("count_bound[%0d]", k), 32'(int'(cnt) <= BD), 32'd1);
                if (valid && ready_v[k]) begin
                    check($sformatf("beat[%0d]", k), 32'(data), 32'(word_of(k, exp_idx)));
                    exp_idx <= exp_idx + 1;
                    beats   <= beats + 1;
                end
            end
        end
    end

    int pulses;
    int got_first;

    initial begin
        for (int k = 0; k < N_INST; k++) begin
            sclr_v[k]  = 1'b1;
            ready_v[k] = 1'b0;
            wr_cnt[k]  = 0;
        end
        repeat (3) step();

        // Reset state
        @(negedge clk);
        check("rst_rdreq0", 32'(g_inst[0].rdreq), 32'd0);
        check("rst_valid0", 32'(g_inst[0].valid), 32'd0);
        check("rst_count0", 32'(g_inst[0].cnt),   32'd0);
        check("rst_count1", 32'(g_inst[1].cnt),   32'd0);
        step();
        sclr_v[0]  = 1'b0;
        ready_v[0] = 1'b1;
        @(negedge clk);
        check("idle_rdreq0", 32'(g_inst[0].rdreq), 32'd0);
        check("idle_valid0", 32'(g_inst[0].valid), 32'd0);
        step();

        // Fill then drain, RL1/BD4: 10 gapless beats, valid 2 cycles after empty falls
        wr_cnt[0] = 10;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("fd_valid", 32'(g_inst[0].valid), 32'((i >= 2) && (i < 12)));
            if (i == 0) check("fd_first_rdreq", 32'(g_inst[0].rdreq), 32'd1);
            step();
        end
        check("fd_beats", 32'(g_inst[0].beats), 32'd10);

        // Backpressure: exactly 4 reads then stall
        ready_v[0] = 1'b0;
        wr_cnt[0]  = 18;
        pulses     = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (g_inst[0].rdreq) pulses++;
            step();
        end
        check("bp_pulses", 32'(pulses), 32'd4);
        @(negedge clk);
        check("bp_count_sat", 32'(g_inst[0].cnt),   32'd4);
        check("bp_no_rdreq",  32'(g_inst[0].rdreq), 32'd0);
        check("bp_head",      32'(g_inst[0].data),  32'(word_of(0, 10)));
        step();
        ready_v[0] = 1'b1;
        @(negedge clk);
        check("bp_pop_rdreq", 32'(g_inst[0].rdreq), 32'd0);
        step();
        ready_v[0] = 1'b0;
        @(negedge clk);
        check("bp_refill_rdreq", 32'(g_inst[0].rdreq), 32'd1);
        check("bp_after_pop",    32'(g_inst[0].cnt),   32'd3);
        step();
        @(negedge clk);
        check("bp_one_rdreq",    32'(g_inst[0].rdreq), 32'd0);
        check("bp_cnt_wait",     32'(g_inst[0].cnt),   32'd3);
        step();
        @(negedge clk);
        check("bp_cnt_full",     32'(g_inst[0].cnt),   32'd4);
        check("bp_new_head",     32'(g_inst[0].data),  32'(word_of(0, 11)));
        check("bp_beats",        32'(g_inst[0].beats), 32'd11);
        step();
        ready_v[0] = 1'b1;
        repeat (12) step();
        check("bp_drain_beats", 32'(g_inst[0].beats), 32'd18);
        check("bp_drain_cnt",   32'(g_inst[0].cnt),   32'd0);

        // Latency sweep, RL3/BD5: first valid 4 cycles after first rdreq, 100 gapless
        sclr_v[1]  = 1'b0;
        ready_v[1] = 1'b1;
        step();
        wr_cnt[1] = 100;
        for (int i = 0; i < 105; i++) begin
            @(negedge clk);
            check("ls_valid", 32'(g_inst[1].valid), 32'((i >= 4) && (i < 104)));
            if (i == 0) check("ls_first_rdreq", 32'(g_inst[1].rdreq), 32'd1);
            step();
        end
        check("ls_beats", 32'(g_inst[1].beats), 32'd100);

        // sclr with 2 reads in flight and 3 buffered
        ready_v[1] = 1'b0;
        wr_cnt[1]  = 108;
        repeat (6) step();
        sclr_v[1] = 1'b1;
        @(negedge clk);
        check("sc_pre_count", 32'(g_inst[1].cnt), 32'd3);
        step();
        sclr_v[1] = 1'b0;
        @(negedge clk);
        check("sc_valid", 32'(g_inst[1].valid), 32'd0);
        check("sc_count", 32'(g_inst[1].cnt),   32'd0);
        check("sc_rdreq", 32'(g_inst[1].rdreq), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            check("sc_late_discard", 32'(g_inst[1].cnt), 32'd0);
        end
        ready_v[1] = 1'b1;
        step();
        wr_cnt[1] = 111;
        got_first = 0;
        for (int i = 0; i < 20 && !got_first; i++) begin
            @(negedge clk);
            if (g_inst[1].valid) begin
                got_first = 1;
                check("sc_first_word", 32'(g_inst[1].data), 32'(word_of(1, 108)));
            end
            step();
        end
        check("sc_first_seen", 32'(got_first), 32'd1);
        repeat (10) step();
        check("sc_beats", 32'(g_inst[1].beats), 32'd103);

        // Random ready on RL1, RL3, RL2
        sclr_v[2] = 1'b0;
        step();
        wr_cnt[0] = 1018;
        wr_cnt[1] = 1111;
        wr_cnt[2] = 1000;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (g_inst[0].beats >= 1018 && g_inst[1].beats >= 1103 && g_inst[2].beats >= 1000) break;
            for (int k = 0; k < 3; k++) ready_v[k] = 1'($urandom_range(0, 1));
            step();
        end
        check("rnd_beats0", 32'(g_inst[0].beats), 32'd1018);
        check("rnd_beats1", 32'(g_inst[1].beats), 32'd1103);
        check("rnd_beats2", 32'(g_inst[2].beats), 32'd1000);

        // Wrap-around, RL1/BD3, ready toggling
        sclr_v[3] = 1'b0;
        step();
        wr_cnt[3] = 20;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (g_inst[3].beats >= 20) break;
            ready_v[3] = ((cyc % 2) == 0);
            step();
        end
        check("wrap_beats",   32'(g_inst[3].beats),   32'd20);
        check("wrap_exp_idx", 32'(g_inst[3].exp_idx), 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
